// File: rtl/const_div_seq_ctrl_if.sv
// Handshake bundle for const_div_seq_ctrl: dividend in (valid/ready), quotient/remainder out (valid/ready).
interface const_div_seq_ctrl_if #(
  parameter int WIDTH = 24,
  parameter int RW    = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quot;
  logic [RW-1:0]    rem;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, quot, rem
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, quot, rem
  );
endinterface

// File: rtl/const_div_seq_ctrl.sv
// Multicycle divide-by-constant: one CHUNK-bit digit per clock, MSB first.
// Optional macro CONST_DIV_SEQ_LZ_SKIP_EN skips leading all-zero chunks on accept.
module const_div_seq_ctrl #(
  parameter int WIDTH   = 24,
  parameter int DIVISOR = 47,
  parameter int CHUNK   = 3,
  parameter int RW      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_clr,
  const_div_seq_ctrl_if.slave   bus,
  output logic                  busy
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int TW    = RW + CHUNK;
  localparam logic [TW-1:0] DIV_T = TW'(DIVISOR);

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of CHUNK");
  end
  if ((DIVISOR % 2 == 0) || (DIVISOR < 3) || (DIVISOR > (1 << RW) - 1)) begin : g_bad_divisor
    $error("DIVISOR must be odd and within 3..2^RW-1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [RW-1:0]    r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Digit step: (r, d) -> (q_digit, r'); r < DIVISOR keeps q_digit within CHUNK bits.
  logic [CHUNK-1:0] digit;
  logic [TW-1:0]    t;
  logic [CHUNK-1:0] q_digit;
  logic [RW-1:0]    r_next;

  assign digit   = sh_q[WIDTH-1 -: CHUNK];
  assign t       = {r_q, digit};
  assign q_digit = CHUNK'(t / DIV_T);
  assign r_next  = RW'(t % DIV_T);

  logic [WIDTH-1:0] load_sh;
  logic [CW-1:0]    load_cnt;

`ifdef CONST_DIV_SEQ_LZ_SKIP_EN
  // A zero dividend still runs one step (d=0 gives q=0, r=0) for a uniform 1-edge latency.
  int sig_chunks;
  always_comb begin
    sig_chunks = 1;
    for (int i = 0; i < STEPS; i++) begin
      if (bus.in_data[i*CHUNK +: CHUNK] != '0) sig_chunks = i + 1;
    end
    load_sh  = bus.in_data << (CHUNK * (STEPS - sig_chunks));
    load_cnt = CW'(sig_chunks - 1);
  end
`else
  assign load_sh  = bus.in_data;
  assign load_cnt = CW'(STEPS - 1);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (soft_clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.in_valid)    state_d = RUN;
        RUN:     if (cnt_q == '0)     state_d = DONE;
        DONE:    if (bus.out_ready)   state_d = IDLE;
        default:                      state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    busy          = (state_q == RUN);
  end

  always_comb begin
    sh_d   = sh_q;
    quot_d = quot_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    if (!soft_clr) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sh_d   = load_sh;
            quot_d = '0;
            r_d    = '0;
            cnt_d  = load_cnt;
          end
        end
        RUN: begin
          r_d    = r_next;
          quot_d = (quot_q << CHUNK) | WIDTH'(q_digit);
          sh_d   = sh_q << CHUNK;
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: datapath registers are reset too, so quot/rem read as zero before the first result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      quot_q <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
    end else begin
      sh_q   <= sh_d;
      quot_q <= quot_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.quot = quot_q;
  assign bus.rem  = r_q;

endmodule

// File: tb/tb_const_div_seq_ctrl.sv
// Directed + short random bench for const_div_seq_ctrl (WIDTH=24, DIVISOR=47, CHUNK=3).
module tb_const_div_seq_ctrl;

  localparam int WIDTH   = 24;
  localparam int DIVISOR = 47;
  localparam int CHUNK   = 3;
  localparam int RW      = 6;
  localparam int STEPS   = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic soft_clr = 1'b0;
  logic busy;

  int n_cmp = 0;
  int n_err = 0;

  const_div_seq_ctrl_if #(.WIDTH(WIDTH), .RW(RW)) bus_if ();

  const_div_seq_ctrl #(
    .WIDTH(WIDTH), .DIVISOR(DIVISOR), .CHUNK(CHUNK), .RW(RW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .soft_clr (soft_clr),
    .bus      (bus_if),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [WIDTH-1:0] data);
`ifdef CONST_DIV_SEQ_LZ_SKIP_EN
    int sig = 1;
    for (int i = 0; i < STEPS; i++)
      if (((data >> (i*CHUNK)) & 24'h7) != 0) sig = i + 1;
    return sig;
`else
    return STEPS;
`endif
  endfunction

  // One full transaction; bp = extra DONE cycles with out_ready low (ignored when early).
  task automatic run_div(input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] eq,
                         input logic [RW-1:0] er, input bit early, input int bp);
    int lat;
    check("in_ready_idle", bus_if.in_ready, 1);
    @(negedge clk);
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = data;
    bus_if.out_ready = early;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = WIDTH'($urandom);
    check("busy_run", busy, 1);
    check("in_ready_run", bus_if.in_ready, 0);
    lat = 1;
    while (!bus_if.out_valid && lat <= 64) begin
      @(posedge clk); #1;
      if (!bus_if.out_valid) lat++;
    end
    check("latency", lat, exp_lat(data));
    check("quot", bus_if.quot, eq);
    check("rem", bus_if.rem, er);
    check("busy_done", busy, 0);
    if (!early) begin
      repeat (bp) begin
        @(posedge clk); #1;
        check("hold_valid", bus_if.out_valid, 1);
      end
      bus_if.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("out_valid_drop", bus_if.out_valid, 0);
    check("in_ready_back", bus_if.in_ready, 1);
    bus_if.out_ready = 1'b0;
  endtask

  // Accept 0xFFFFFF and advance four RUN steps: partial quot=87, rem=6.
  task automatic start_partial();
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 24'hFFFFFF;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("partial_quot", bus_if.quot, 87);
    check("partial_rem", bus_if.rem, 6);
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] d;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus_if.in_ready, 1);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quot", bus_if.quot, 0);
    check("rst_rem", bus_if.rem, 0);
    @(negedge clk) rst = 1'b0;

    run_div(24'hFFFFFF, 24'h057262, 1, 1'b1, 0);
    run_div(1000, 21, 13, 1'b0, 0);
    run_div(47, 1, 0, 1'b0, 2);
    run_div(46, 0, 46, 1'b1, 0);
    run_div(0, 0, 0, 1'b0, 1);
    run_div(5, 0, 5, 1'b1, 0);
    run_div(24'h000400, 21, 37, 1'b0, 0);

    // In_valid pulses during RUN/DONE must not be latched; DONE holds under backpressure.
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 24'hFFFFFF;
    @(posedge clk); #1;
    bus_if.in_data = 24'd5;
    lat = 1;
    while (!bus_if.out_valid && lat <= 64) begin
      @(negedge clk) bus_if.in_valid = ~bus_if.in_valid;
      @(posedge clk); #1;
      if (!bus_if.out_valid) lat++;
    end
    check("hold_latency", lat, exp_lat(24'hFFFFFF));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) bus_if.in_valid = ~bus_if.in_valid;
      @(posedge clk); #1;
      check("hold_valid", bus_if.out_valid, 1);
      check("hold_quot", bus_if.quot, 356962);
      check("hold_rem", bus_if.rem, 1);
      check("hold_in_ready", bus_if.in_ready, 0);
    end
    @(negedge clk);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", bus_if.in_ready, 1);
    bus_if.out_ready = 1'b0;

    // Asynchronous reset mid-RUN.
    start_partial();
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", bus_if.in_ready, 1);
    check("arst_out_valid", bus_if.out_valid, 0);
    check("arst_quot", bus_if.quot, 0);
    check("arst_rem", bus_if.rem, 0);
    @(negedge clk) rst = 1'b0;
    run_div(94, 2, 0, 1'b0, 0);

    // Soft clear mid-RUN, then soft clear beating an accept in IDLE.
    start_partial();
    @(negedge clk);
    soft_clr        = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 24'd1000;
    @(posedge clk); #1;
    check("sclr_busy", busy, 0);
    check("sclr_in_ready", bus_if.in_ready, 1);
    check("sclr_out_valid", bus_if.out_valid, 0);
    check("sclr_quot_kept", bus_if.quot, 87);
    check("sclr_rem_kept", bus_if.rem, 6);
    @(posedge clk); #1;
    check("sclr_no_accept", busy, 0);
    check("sclr_no_load", bus_if.quot, 87);
    @(negedge clk);
    soft_clr        = 1'b0;
    bus_if.in_valid = 1'b0;
    run_div(94, 2, 0, 1'b1, 0);

    // Random sweep against the arithmetic model.
    for (int i = 0; i < 400; i++) begin
      d = (i % 4 == 0) ? WIDTH'($urandom_range(0, 200)) : WIDTH'($urandom);
      run_div(d, d / DIVISOR, RW'(d % DIVISOR), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
